fetch_sequencer: RTL and testbench

Parametrised program-counter sequencer for the next-generation core, replacing the bare PC plus hard-coded done compare in the top level. Each instruction cycle it selects the next fetch address from increment, absolute jump, signed relative jump, call or return. It keeps a return-address stack of configurable depth and raises a sticky `done` when the program reaches a configurable halt address. It sits between the control decoder and `instr_ROM`, driving `prog_ctr`.

---
 rtl/fetch_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: next fetch address from increment, jumps, call or return.
// Define FETCH_RAS_EN to build the return-address stack; undefined = no stack.
module fetch_sequencer #(
   parameter int D          = 10,
   parameter int RAS_DEPTH  = 4,
   parameter int START_ADDR = 0,
   parameter int DONE_ADDR  = 109
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       absjump_en,
   input  logic                       reljump_en,
   input  logic                       call_en,
   input  logic                       ret_en,
   input  logic [D-1:0]               target,
   input  logic [7:0]                 rel_off,
   output logic [D-1:0]               prog_ctr,
   output logic                       done,
   output logic [$clog2(RAS_DEPTH):0] ras_count,
   output logic                       ras_ovf,
   output logic                       ras_unf
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   localparam logic [D-1:0] START_PC = D'(START_ADDR);
   localparam logic [D-1:0] HALT_PC  = D'(DONE_ADDR);

   logic [D-1:0] pc_q, pc_d;
   logic         done_q, done_d;
   logic [D-1:0] pc_inc;
   logic [D-1:0] rel_ext;
   logic [D-1:0] pc_rel;
   logic         frozen;
   logic         halt_hit;

   assign pc_inc   = pc_q + D'(1);
   assign pc_rel   = pc_q + rel_ext;
   assign frozen   = done_q | stall;
   assign halt_hit = (pc_q == HALT_PC);

   // Offset is sign-extended for wide PCs, truncated for narrow ones.
   generate
      if (D > 8) begin : g_sext
         assign rel_ext = {{(D-8){rel_off[7]}}, rel_off};
      end else begin : g_trunc
         assign rel_ext = rel_off[D-1:0];
      end
   endgenerate

`ifdef FETCH_RAS_EN

   localparam logic [CW-1:0] FULL_CNT = CW'(RAS_DEPTH);

   logic [D-1:0]  stack_q [RAS_DEPTH];
   logic [PW-1:0] ptr_q, ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          push;
   logic [PW-1:0] top_idx;
   logic          empty;
   logic          full;

   // ptr_q is the next write slot; the newest entry sits just below it.
   assign top_idx = ptr_q - PW'(1);
   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == FULL_CNT);

   // Next-state selection in priority order; a full push wraps over the oldest.
   always_comb begin
      pc_d   = pc_q;
      done_d = done_q;
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      unf_d  = unf_q;
      push   = 1'b0;
      priority case (1'b1)
         frozen: begin
            pc_d = pc_q;
         end
         halt_hit: begin
            done_d = 1'b1;
         end
         ret_en: begin
            if (empty) begin
               pc_d  = pc_inc;
               unf_d = 1'b1;
            end else begin
               pc_d  = stack_q[top_idx];
               ptr_d = top_idx;
               cnt_d = cnt_q - CW'(1);
            end
         end
         call_en: begin
            pc_d  = target;
            push  = 1'b1;
            ptr_d = ptr_q + PW'(1);
            if (full) begin
               ovf_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         absjump_en: begin
            pc_d = target;
         end
         reljump_en: begin
            pc_d = pc_rel;
         end
         default: begin
            pc_d = pc_inc;
         end
      endcase
   end

   // Stack storage carries no reset; only entries below ras_count are read.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_q[ptr_q] <= pc_inc;
      end
   end

   // Stack bookkeeping registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign ras_count = cnt_q;
   assign ras_ovf   = ovf_q;
   assign ras_unf   = unf_q;

`else

   logic unused_ret;

   assign unused_ret = ret_en;

   // Next-state selection; a call is just a jump when there is no stack.
   always_comb begin
      pc_d   = pc_q;
      done_d = done_q;
      priority case (1'b1)
         frozen: begin
            pc_d = pc_q;
         end
         halt_hit: begin
            done_d = 1'b1;
         end
         call_en: begin
            pc_d = target;
         end
         absjump_en: begin
            pc_d = target;
         end
         reljump_en: begin
            pc_d = pc_rel;
         end
         default: begin
            pc_d = pc_inc;
         end
      endcase
   end

   assign ras_count = '0;
   assign ras_ovf   = 1'b0;
   assign ras_unf   = 1'b0;

`endif

   // Program counter and sticky halt flag.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q   <= START_PC;
         done_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         done_q <= done_d;
      end
   end

   assign prog_ctr = pc_q;
   assign done     = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: scoreboard bench against a queue-based reference model.
// Works with or without FETCH_RAS_EN defined.
module tb_fetch_sequencer;

   localparam int D     = 10;
   localparam int DEPTH = 4;
   localparam int START = 0;
   localparam int HALT  = 109;
   localparam int MOD   = 1 << D;
`ifdef FETCH_RAS_EN
   localparam bit RAS = 1'b1;
`else
   localparam bit RAS = 1'b0;
`endif

   typedef struct {
      int pc;
      int dn;
      int cnt;
      int ovf;
      int unf;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stall = 1'b0;
   logic absjump_en = 1'b0;
   logic reljump_en = 1'b0;
   logic call_en = 1'b0;
   logic ret_en = 1'b0;
   logic [D-1:0] target = '0;
   logic [7:0] rel_off = '0;
   logic [D-1:0] prog_ctr;
   logic done;
   logic [$clog2(DEPTH):0] ras_count;
   logic ras_ovf;
   logic ras_unf;

   int checks = 0;
   int errors = 0;

   exp_t sb[$];

   int m_pc;
   bit m_done, m_ovf, m_unf;
   int m_stk[$];

   fetch_sequencer #(
      .D(D), .RAS_DEPTH(DEPTH), .START_ADDR(START), .DONE_ADDR(HALT)
   ) dut (
      .clk(clk), .reset(rst_n), .stall(stall),
      .absjump_en(absjump_en), .reljump_en(reljump_en),
      .call_en(call_en), .ret_en(ret_en),
      .target(target), .rel_off(rel_off),
      .prog_ctr(prog_ctr), .done(done), .ras_count(ras_count),
      .ras_ovf(ras_ovf), .ras_unf(ras_unf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one instruction cycle from the rules, using plain ints and a queue.
   task automatic model_step(input bit st, input bit ab, input bit rj,
                             input bit cl, input bit rt,
                             input int tgt, input int ro);
      if (m_done || st) begin
      end else if (m_pc == HALT) begin
         m_done = 1'b1;
      end else if (RAS && rt && m_stk.size() > 0) begin
         m_pc = m_stk.pop_back();
      end else if (RAS && rt) begin
         m_unf = 1'b1;
         m_pc = (m_pc + 1) % MOD;
      end else if (cl) begin
         if (RAS) begin
            m_stk.push_back((m_pc + 1) % MOD);
            if (m_stk.size() > DEPTH) begin
               void'(m_stk.pop_front());
               m_ovf = 1'b1;
            end
         end
         m_pc = tgt;
      end else if (ab) begin
         m_pc = tgt;
      end else if (rj) begin
         m_pc = ((m_pc + ro) % MOD + MOD) % MOD;
      end else begin
         m_pc = (m_pc + 1) % MOD;
      end
   endtask

   task automatic drive(input bit st, input bit ab, input bit rj,
                        input bit cl, input bit rt,
                        input int tgt, input int ro);
      logic [7:0] rv;
      exp_t e;
      @(negedge clk);
      rv = 8'(ro);
      rst_n = 1'b1;
      stall = st;
      absjump_en = ab;
      reljump_en = rj;
      call_en = cl;
      ret_en = rt;
      target = D'(tgt);
      rel_off = rv;
      model_step(st, ab, rj, cl, rt, tgt % MOD, int'($signed(rv)));
      e.pc = m_pc;
      e.dn = int'(m_done);
      e.cnt = m_stk.size();
      e.ovf = int'(m_ovf);
      e.unf = int'(m_unf);
      sb.push_back(e);
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic post(input string name, input int exp_pc);
      @(posedge clk);
      #2;
      chk(name, int'(prog_ctr), exp_pc);
   endtask

   // Asynchronous reset at mid-cycle; released by the next drive at a negedge.
   task automatic reset_dut();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_pc", int'(prog_ctr), START);
      chk("rst_done", int'(done), 0);
      chk("rst_cnt", int'(ras_count), 0);
      chk("rst_ovf", int'(ras_ovf), 0);
      chk("rst_unf", int'(ras_unf), 0);
      m_pc = START;
      m_done = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_stk.delete();
      stall = 1'b0;
      absjump_en = 1'b0;
      reljump_en = 1'b0;
      call_en = 1'b0;
      ret_en = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   // Monitor: every clock edge with an outstanding expectation is compared.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("sb_pc", int'(prog_ctr), e.pc);
            chk("sb_done", int'(done), e.dn);
            chk("sb_cnt", int'(ras_count), e.cnt);
            chk("sb_ovf", int'(ras_ovf), e.ovf);
            chk("sb_unf", int'(ras_unf), e.unf);
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   int rets_ras[5] = '{51, 41, 31, 21, 22};
   int rets_nor[5] = '{61, 62, 63, 64, 65};

   initial begin
      int r;
      reset_dut();
      repeat (20) idle();
      drive(0, 0, 1, 0, 0, 0, 'hF6);
      post("rel_back", 10);
      drive(0, 1, 0, 0, 0, 1020, 0);
      drive(0, 0, 1, 0, 0, 0, 10);
      post("rel_wrap", 6);
      drive(0, 1, 0, 0, 0, 1023, 0);
      idle();
      post("inc_wrap", 0);

      drive(0, 1, 0, 0, 0, 5, 0);
      drive(0, 0, 0, 1, 0, 100, 0);
      post("call_pc", 100);
      chk("call_cnt", int'(ras_count), RAS ? 1 : 0);
      idle();
      idle();
      drive(0, 0, 0, 0, 1, 0, 0);
      post("ret_pc", RAS ? 6 : 103);
      chk("ret_cnt", int'(ras_count), 0);

      reset_dut();
      drive(0, 1, 0, 0, 0, 10, 0);
      for (int k = 0; k < 5; k++) drive(0, 0, 0, 1, 0, 20 + 10 * k, 0);
      post("nest_pc", 60);
      chk("nest_cnt", int'(ras_count), RAS ? 4 : 0);
      chk("nest_ovf", int'(ras_ovf), RAS ? 1 : 0);
      for (int k = 0; k < 5; k++) begin
         drive(0, 0, 0, 0, 1, 0, 0);
         post("nest_ret", RAS ? rets_ras[k] : rets_nor[k]);
      end
      chk("nest_unf", int'(ras_unf), RAS ? 1 : 0);

      reset_dut();
      drive(0, 0, 0, 1, 0, 200, 0);
      drive(1, 1, 1, 1, 1, 7, 3);
      post("stall_pc", 200);
      chk("stall_cnt", int'(ras_count), RAS ? 1 : 0);
      drive(0, 1, 0, 1, 1, 300, 0);
      post("multi_pc", RAS ? 1 : 300);
      chk("multi_cnt", int'(ras_count), 0);

      reset_dut();
      drive(0, 1, 0, 0, 0, 105, 0);
      repeat (4) idle();
      idle();
      post("halt_pc", HALT);
      chk("halt_done", int'(done), 1);
      for (int k = 0; k < 10; k++) begin
         drive(0, 1, 0, 0, 0, int'($urandom_range(0, MOD - 1)), 0);
         post("halt_hold", HALT);
      end
      reset_dut();

      for (int i = 0; i < 600; i++) begin
         if (m_done && $urandom_range(0, 3) == 0) reset_dut();
         r = int'($urandom_range(0, 99));
         drive(r < 8,
               $urandom_range(0, 9) == 0,
               $urandom_range(0, 5) == 0,
               $urandom_range(0, 6) == 0,
               $urandom_range(0, 5) == 0,
               int'($urandom_range(0, MOD - 1)),
               int'($urandom_range(0, 255)));
      end

      repeat (2) @(posedge clk);
      #2;
      chk("sb_drain", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
